// File: rtl/openofdm_rx_seq_ctrl_pkg.sv
// Shared definitions for the dot11 receive sequencer: FSM state encodings
// (also exported on the seq_state debug port) and abort cause codes.
package openofdm_rx_seq_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_RST      = 3'd0,
      ST_IDLE     = 3'd1,
      ST_DEMOD    = 3'd2,
      ST_ABORT    = 3'd3,
      ST_TX_BLANK = 3'd4,
      ST_HOLD     = 3'd5
   } seq_state_t;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
   localparam logic [1:0] CAUSE_HT      = 2'b10;
   localparam logic [1:0] CAUSE_TX      = 2'b11;

endpackage

// File: rtl/openofdm_rx_seq_ctrl_sat_counter.sv
// Saturating statistics counter.
// Ports: clock, reset (async, active-high), inc (count one event),
//        clr (synchronous clear, wins over inc), count (current value).
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
      return (&v) ? v : v + ONE;
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc)
         count <= sat_inc(count);
   end

endmodule

// File: rtl/openofdm_rx_seq_ctrl.sv
// Sequencer between the register file and the dot11 receive core.
// Drives core enable/reset, blanks RX while local TX is busy, aborts a
// stalled or unsupported demod, and keeps saturating packet/abort counters.
// Ports:
//   clock, reset                 receive clock, async active-high reset
//   sw_reset, sw_disable         software core reset / receive disable (levels)
//   tx_busy                      local TX chain active
//   cfg_watchdog, cfg_tx_hold    watchdog timeout (0 = off), post-TX settle cycles
//   cnt_clear                    clears all counters
//   demod_is_ongoing .. fcs_ok   status strobes from the dot11 core
//   core_enable, core_reset      controls to the dot11 core
//   abort_strobe, abort_cause    abort pulse and last abort reason
//   seq_state                    FSM state for debug readback
//   pkt_ok_cnt, pkt_err_cnt, abort_cnt  statistics
module openofdm_rx_seq_ctrl
   import openofdm_rx_seq_ctrl_pkg::*;
#(
   parameter int RST_CYCLES  = 4,
   parameter int TIMER_WIDTH = 20,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   sw_reset,
   input  logic                   sw_disable,
   input  logic                   tx_busy,
   input  logic [TIMER_WIDTH-1:0] cfg_watchdog,
   input  logic [TIMER_WIDTH-1:0] cfg_tx_hold,
   input  logic                   cnt_clear,
   input  logic                   demod_is_ongoing,
   input  logic                   pkt_header_valid_strobe,
   input  logic                   ht_unsupport,
   input  logic                   byte_out_strobe,
   input  logic                   fcs_out_strobe,
   input  logic                   fcs_ok,
   output logic                   core_enable,
   output logic                   core_reset,
   output logic                   abort_strobe,
   output logic [1:0]             abort_cause,
   output logic [2:0]             seq_state,
   output logic [CNT_WIDTH-1:0]   pkt_ok_cnt,
   output logic [CNT_WIDTH-1:0]   pkt_err_cnt,
   output logic [CNT_WIDTH-1:0]   abort_cnt
);

   localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RW-1:0]          RST_LAST = RW'(RST_CYCLES - 1);
   localparam logic [RW-1:0]          RST_ONE  = RW'(1);
   localparam logic [TIMER_WIDTH-1:0] T_ONE    = TIMER_WIDTH'(1);

   seq_state_t             state, next;
   logic [RW-1:0]          rst_cnt, rst_cnt_n;
   logic [TIMER_WIDTH-1:0] wd, wd_n, hold, hold_n;
   logic                   wd_en, wd_en_n;
   logic [1:0]             cause_n;
   logic                   reload, ok_inc, err_inc, ab_inc;

   // Timers stop at zero instead of wrapping.
   function automatic logic [TIMER_WIDTH-1:0] sat_dec(input logic [TIMER_WIDTH-1:0] t);
      return (t == '0) ? t : t - T_ONE;
   endfunction

   always_comb begin
      next      = state;
      rst_cnt_n = rst_cnt;
      wd_n      = wd;
      wd_en_n   = wd_en;
      hold_n    = hold;
      cause_n   = abort_cause;
      reload    = 1'b0;
      ok_inc    = 1'b0;
      err_inc   = 1'b0;
      ab_inc    = 1'b0;
      case (state)
         ST_RST: begin
            if (rst_cnt == RST_LAST) begin
               next      = tx_busy ? ST_TX_BLANK : ST_IDLE;
               rst_cnt_n = '0;
            end else begin
               rst_cnt_n = rst_cnt + RST_ONE;
            end
         end
         ST_IDLE: begin
            if (tx_busy) begin
               next = ST_TX_BLANK;
            end else if (demod_is_ongoing && !sw_disable) begin
               next    = ST_DEMOD;
               wd_n    = cfg_watchdog;
               wd_en_n = |cfg_watchdog;
            end
         end
         ST_DEMOD: begin
            reload = byte_out_strobe | pkt_header_valid_strobe;
            if (reload) begin
               wd_n    = cfg_watchdog;
               wd_en_n = |cfg_watchdog;
            end else begin
               wd_n = sat_dec(wd);
            end
            if (fcs_out_strobe) begin
               ok_inc  = fcs_ok;
               err_inc = ~fcs_ok;
               next    = ST_IDLE;
            end else if (tx_busy) begin
               next    = ST_ABORT;
               cause_n = CAUSE_TX;
            end else if (pkt_header_valid_strobe && ht_unsupport) begin
               next    = ST_ABORT;
               cause_n = CAUSE_HT;
            end else if (wd_en && !reload && (wd <= T_ONE)) begin
               // The decrement this cycle reaches zero.
               next    = ST_ABORT;
               cause_n = CAUSE_TIMEOUT;
            end else if (!demod_is_ongoing) begin
               next = ST_IDLE;
            end
         end
         ST_ABORT: begin
            ab_inc    = 1'b1;
            next      = ST_RST;
            rst_cnt_n = '0;
         end
         ST_TX_BLANK: begin
            if (!tx_busy) begin
               next   = ST_HOLD;
               hold_n = cfg_tx_hold;
            end
         end
         ST_HOLD: begin
            if (tx_busy) begin
               next = ST_TX_BLANK;
            end else if (hold <= T_ONE) begin
               // A zero hold still spends one cycle here.
               next      = ST_RST;
               rst_cnt_n = '0;
            end else begin
               hold_n = sat_dec(hold);
            end
         end
         default: begin
            next      = ST_RST;
            rst_cnt_n = '0;
         end
      endcase
      // Software reset pins RST and drops any pending count or abort.
      if (sw_reset) begin
         next      = ST_RST;
         rst_cnt_n = '0;
         cause_n   = abort_cause;
         ok_inc    = 1'b0;
         err_inc   = 1'b0;
         ab_inc    = 1'b0;
      end
   end

   // Registered state, timers and outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= ST_RST;
         rst_cnt      <= '0;
         wd           <= '0;
         wd_en        <= 1'b0;
         hold         <= '0;
         core_reset   <= 1'b1;
         core_enable  <= 1'b0;
         abort_strobe <= 1'b0;
         abort_cause  <= CAUSE_NONE;
      end else begin
         state        <= next;
         rst_cnt      <= rst_cnt_n;
         wd           <= wd_n;
         wd_en        <= wd_en_n;
         hold         <= hold_n;
         core_reset   <= (next == ST_RST);
         core_enable  <= (next == ST_DEMOD) || ((next == ST_IDLE) && !sw_disable);
         abort_strobe <= (next == ST_ABORT);
         abort_cause  <= cause_n;
      end
   end

   assign seq_state = state;

   sat_counter #(.WIDTH(CNT_WIDTH)) u_ok_cnt (
      .clock (clock), .reset (reset), .inc (ok_inc), .clr (cnt_clear), .count (pkt_ok_cnt)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
      .clock (clock), .reset (reset), .inc (err_inc), .clr (cnt_clear), .count (pkt_err_cnt)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_abort_cnt (
      .clock (clock), .reset (reset), .inc (ab_inc), .clr (cnt_clear), .count (abort_cnt)
   );

endmodule

// File: tb/tb_openofdm_rx_seq_ctrl.sv
// Bench for openofdm_rx_seq_ctrl. Counters are built 4 bits wide so that
// saturation is reachable with a handful of frames.
module tb_openofdm_rx_seq_ctrl;

   localparam int TW = 20;
   localparam int CW = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          sw_reset = 1'b0, sw_disable = 1'b0, tx_busy = 1'b0;
   logic [TW-1:0] cfg_watchdog = '0, cfg_tx_hold = '0;
   logic          cnt_clear = 1'b0, demod_is_ongoing = 1'b0;
   logic          pkt_header_valid_strobe = 1'b0, ht_unsupport = 1'b0;
   logic          byte_out_strobe = 1'b0, fcs_out_strobe = 1'b0, fcs_ok = 1'b0;
   logic          core_enable, core_reset, abort_strobe;
   logic [1:0]    abort_cause;
   logic [2:0]    seq_state;
   logic [CW-1:0] pkt_ok_cnt, pkt_err_cnt, abort_cnt;

   openofdm_rx_seq_ctrl #(.RST_CYCLES(4), .TIMER_WIDTH(TW), .CNT_WIDTH(CW)) dut (
      .clock                   (clock),
      .reset                   (reset),
      .sw_reset                (sw_reset),
      .sw_disable              (sw_disable),
      .tx_busy                 (tx_busy),
      .cfg_watchdog            (cfg_watchdog),
      .cfg_tx_hold             (cfg_tx_hold),
      .cnt_clear               (cnt_clear),
      .demod_is_ongoing        (demod_is_ongoing),
      .pkt_header_valid_strobe (pkt_header_valid_strobe),
      .ht_unsupport            (ht_unsupport),
      .byte_out_strobe         (byte_out_strobe),
      .fcs_out_strobe          (fcs_out_strobe),
      .fcs_ok                  (fcs_ok),
      .core_enable             (core_enable),
      .core_reset              (core_reset),
      .abort_strobe            (abort_strobe),
      .abort_cause             (abort_cause),
      .seq_state               (seq_state),
      .pkt_ok_cnt              (pkt_ok_cnt),
      .pkt_err_cnt             (pkt_err_cnt),
      .abort_cnt               (abort_cnt)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [1:0] cause;
      int         cnt;
   } ab_t;

   ab_t ab_q[$];
   int  pkt_q[$];
   int  ok_m = 0, err_m = 0, ab_m = 0;

   // Scoreboard monitor: counter changes and abort pulses pop expectations.
   logic [CW-1:0] prev_ok, prev_err;
   bit            pend;
   int            pend_cnt;
   ab_t           e_m;
   initial begin
      prev_ok = '0; prev_err = '0; pend = 1'b0; pend_cnt = 0;
      forever begin
         @(negedge clock);
         if (!reset) begin
            if (pkt_ok_cnt !== prev_ok || pkt_err_cnt !== prev_err) begin
               if (pkt_q.size() == 0)
                  chk("pkt_unexpected", 32'(pkt_ok_cnt) * 256 + 32'(pkt_err_cnt),
                      32'(prev_ok) * 256 + 32'(prev_err));
               else
                  chk("pkt_cnt", 32'(pkt_ok_cnt) * 256 + 32'(pkt_err_cnt), 32'(pkt_q.pop_front()));
               prev_ok  = pkt_ok_cnt;
               prev_err = pkt_err_cnt;
            end
            if (pend) begin
               chk("abort_cnt", 32'(abort_cnt), 32'(pend_cnt));
               pend = 1'b0;
            end
            if (abort_strobe) begin
               if (ab_q.size() == 0) begin
                  chk("abort_unexpected", 32'(abort_strobe), 32'd0);
               end else begin
                  e_m = ab_q.pop_front();
                  chk("abort_cause", 32'(abort_cause), 32'(e_m.cause));
                  pend     = 1'b1;
                  pend_cnt = e_m.cnt;
               end
            end
         end
      end
   end

   task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
      int i = 0;
      while (seq_state !== s && i < budget) begin
         @(negedge clock);
         i++;
      end
      chk(tag, 32'(seq_state), 32'(s));
   endtask

   // Counts consecutive cycles with core_reset high, starting at the current sample.
   task automatic rst_len(input string tag);
      int n = 0;
      for (int i = 0; i < 40 && core_reset === 1'b1; i++) begin
         n++;
         @(negedge clock);
      end
      chk(tag, 32'(n), 32'd4);
   endtask

   task automatic frame(input int nbytes, input bit ok, input bit clr, input bit push);
      demod_is_ongoing = 1'b1;
      @(negedge clock);
      chk("frame_demod", 32'(seq_state), 32'd2);
      byte_out_strobe = 1'b1;
      repeat (nbytes) @(negedge clock);
      byte_out_strobe  = 1'b0;
      fcs_out_strobe   = 1'b1;
      fcs_ok           = ok;
      demod_is_ongoing = 1'b0;
      cnt_clear        = clr;
      if (push) begin
         if (clr) begin
            ok_m = 0; err_m = 0; ab_m = 0;
         end else if (ok) begin
            ok_m++;
         end else begin
            err_m++;
         end
         pkt_q.push_back(ok_m * 256 + err_m);
      end
      @(negedge clock);
      fcs_out_strobe = 1'b0;
      fcs_ok         = 1'b0;
      cnt_clear      = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: time=%0t limit=500000", $time);
      $fatal(1);
   end

   initial begin
      int n;
      int en_bad;
      repeat (3) @(negedge clock);
      chk("rst_state", 32'(seq_state), 32'd0);
      chk("rst_core_reset", 32'(core_reset), 32'd1);
      chk("rst_core_enable", 32'(core_enable), 32'd0);
      chk("rst_abort_strobe", 32'(abort_strobe), 32'd0);
      chk("rst_abort_cause", 32'(abort_cause), 32'd0);
      chk("rst_counters", 32'(pkt_ok_cnt) + 32'(pkt_err_cnt) + 32'(abort_cnt), 32'd0);

      // T1: reset release
      cfg_watchdog = 100;
      cfg_tx_hold  = 50;
      reset = 1'b0;
      rst_len("t1_rst_len");
      chk("t1_enable", 32'(core_enable), 32'd1);
      chk("t1_state", 32'(seq_state), 32'd1);

      // T2: good frame, then a bad one
      frame(40, 1'b1, 1'b0, 1'b1);
      chk("t2_idle", 32'(seq_state), 32'd1);
      frame(3, 1'b0, 1'b0, 1'b1);

      // T3: watchdog timeout
      ab_m++;
      ab_q.push_back('{2'b01, ab_m});
      demod_is_ongoing = 1'b1;
      @(negedge clock);
      n = 1;
      while (!abort_strobe && n < 300) begin
         @(negedge clock);
         n++;
      end
      demod_is_ongoing = 1'b0;
      chk("t3_wd_cycles", 32'(n), 32'd101);
      @(negedge clock);
      rst_len("t3_rst_len");
      wait_state(3'd1, 20, "t3_idle");
      chk("t3_cause_latched", 32'(abort_cause), 32'd1);

      // T4: FCS wins over a same-cycle HT-unsupported header
      demod_is_ongoing = 1'b1;
      @(negedge clock);
      pkt_header_valid_strobe = 1'b1; ht_unsupport = 1'b1;
      fcs_out_strobe = 1'b1; fcs_ok = 1'b1; demod_is_ongoing = 1'b0;
      ok_m++;
      pkt_q.push_back(ok_m * 256 + err_m);
      @(negedge clock);
      pkt_header_valid_strobe = 1'b0; ht_unsupport = 1'b0;
      fcs_out_strobe = 1'b0; fcs_ok = 1'b0;
      @(negedge clock);
      chk("t4_idle", 32'(seq_state), 32'd1);

      // HT-unsupported abort on its own
      ab_m++;
      ab_q.push_back('{2'b10, ab_m});
      demod_is_ongoing = 1'b1;
      @(negedge clock);
      pkt_header_valid_strobe = 1'b1; ht_unsupport = 1'b1;
      @(negedge clock);
      pkt_header_valid_strobe = 1'b0; ht_unsupport = 1'b0; demod_is_ongoing = 1'b0;
      wait_state(3'd1, 20, "ht_idle");

      // demod drop returns to IDLE without counting
      demod_is_ongoing = 1'b1;
      @(negedge clock);
      demod_is_ongoing = 1'b0;
      @(negedge clock);
      chk("drop_idle", 32'(seq_state), 32'd1);

      // watchdog disabled with cfg_watchdog = 0
      cfg_watchdog = 0;
      demod_is_ongoing = 1'b1;
      repeat (150) @(negedge clock);
      chk("wd_off_demod", 32'(seq_state), 32'd2);
      demod_is_ongoing = 1'b0;
      @(negedge clock);

      // sw_disable only honoured in IDLE
      sw_disable = 1'b1;
      @(negedge clock);
      chk("dis_enable", 32'(core_enable), 32'd0);
      demod_is_ongoing = 1'b1;
      repeat (3) @(negedge clock);
      chk("dis_idle", 32'(seq_state), 32'd1);
      sw_disable = 1'b0;
      @(negedge clock);
      chk("dis_release", 32'(seq_state), 32'd2);
      sw_disable = 1'b1;
      repeat (3) @(negedge clock);
      chk("dis_no_interrupt", 32'(seq_state), 32'd2);
      chk("dis_demod_enable", 32'(core_enable), 32'd1);
      demod_is_ongoing = 1'b0;
      @(negedge clock);
      chk("dis_back_idle", 32'(seq_state), 32'd1);
      chk("dis_idle_enable", 32'(core_enable), 32'd0);
      sw_disable = 1'b0;
      @(negedge clock);

      // T5: TX preemption, blanking and hold
      ab_m++;
      ab_q.push_back('{2'b11, ab_m});
      demod_is_ongoing = 1'b1;
      @(negedge clock);
      tx_busy = 1'b1;
      demod_is_ongoing = 1'b0;
      en_bad = 0;
      repeat (500) begin
         @(negedge clock);
         if (core_enable !== 1'b0) en_bad++;
      end
      chk("t5_blank_state", 32'(seq_state), 32'd4);
      tx_busy = 1'b0;
      @(negedge clock);
      n = 0;
      while (seq_state === 3'd5 && n < 200) begin
         if (core_enable !== 1'b0) en_bad++;
         n++;
         @(negedge clock);
      end
      chk("t5_hold_cycles", 32'(n), 32'd50);
      chk("t5_enable_low", 32'(en_bad), 32'd0);
      rst_len("t5_rst_len");
      chk("t5_idle", 32'(seq_state), 32'd1);
      chk("t5_enable", 32'(core_enable), 32'd1);

      // T6: saturation, clear priority, sw_reset during ABORT
      while (ok_m < 15) frame(1, 1'b1, 1'b0, 1'b1);
      frame(1, 1'b1, 1'b0, 1'b0);
      chk("t6_sat_ok", 32'(pkt_ok_cnt), 32'd15);
      frame(1, 1'b0, 1'b1, 1'b1);
      chk("t6_clr_abort", 32'(abort_cnt), 32'd0);

      ab_q.push_back('{2'b10, ab_m});
      demod_is_ongoing = 1'b1;
      @(negedge clock);
      pkt_header_valid_strobe = 1'b1; ht_unsupport = 1'b1;
      @(negedge clock);
      pkt_header_valid_strobe = 1'b0; ht_unsupport = 1'b0; demod_is_ongoing = 1'b0;
      chk("t6_in_abort", 32'(seq_state), 32'd3);
      sw_reset = 1'b1;
      repeat (5) @(negedge clock);
      chk("t6_swrst_state", 32'(seq_state), 32'd0);
      chk("t6_swrst_core_reset", 32'(core_reset), 32'd1);
      sw_reset = 1'b0;
      rst_len("t6_swrst_len");
      wait_state(3'd1, 20, "t6_idle");
      chk("t6_abort_cnt_kept", 32'(abort_cnt), 32'(ab_m));

      repeat (3) @(negedge clock);
      chk("pkt_q_empty", 32'(pkt_q.size()), 32'd0);
      chk("ab_q_empty", 32'(ab_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
